// File: rtl/dfi_phase_sequencer.sv
// Purpose: N-phase DFI sequencer; builds DQ/DQS output-enable windows and read-valid strobes from per-phase enables.
// Latency: write windows start at slot S+wrlat-1; read valid appears rdlat cycles after the enable; all outputs registered.
// Backpressure: none; enables are accepted every cycle and config loads are refused (cfg_err) unless the block is idle.
module dfi_phase_sequencer #(
   parameter int NPHASES   = 2,
   parameter int LAT_W     = 4,
   parameter int RDLAT_MAX = 15,
   parameter int WRLAT_MAX = 7,
   parameter int RDLAT_RST = 4,
   parameter int WRLAT_RST = 3
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               cfg_load,
   input  logic [LAT_W-1:0]   cfg_rdlat,
   input  logic [LAT_W-1:0]   cfg_wrlat,
   input  logic [NPHASES-1:0] dfi_wrdata_en,
   input  logic [NPHASES-1:0] dfi_rddata_en,
   output logic [NPHASES-1:0] dfi_rddata_valid,
   output logic [NPHASES-1:0] oe_dq,
   output logic [NPHASES-1:0] oe_dqs,
   output logic               idle,
   output logic               cfg_err,
   output logic               proto_err
);

   // Slot pipeline covers the furthest postamble slot (phase NPHASES-1, wrlat=WRLAT_MAX, +1) plus margin.
   localparam int WDEPTH = WRLAT_MAX + 2 + NPHASES;

   // Pending write bits: during cycle c, bit j stands for global slot c*NPHASES + j.
   logic [WDEPTH-1:0]  dq_pend_q, dq_pend_d, dq_merge;
   logic [WDEPTH-1:0]  dqs_pend_q, dqs_pend_d, dqs_merge;
   // Read pipe: during cycle c, entry j holds the valids due in cycle c+1+j.
   logic [NPHASES-1:0] rd_pipe_q [RDLAT_MAX];
   logic [NPHASES-1:0] rd_pipe_d [RDLAT_MAX];
   logic [NPHASES-1:0] rd_merge  [RDLAT_MAX];
   logic [NPHASES-1:0] oe_dq_q, oe_dq_d, oe_dqs_q, oe_dqs_d, valid_q, valid_d;
   logic [LAT_W-1:0]   rdlat_q, rdlat_d, wrlat_q, wrlat_d;
   logic               cfg_err_q, cfg_err_d, proto_err_q, proto_err_d;
   logic               busy, cfg_ok;

   // Write windows: merge new enables into the slot pipeline, emit this cycle's slots, shift by one cycle.
   always_comb begin
      dq_merge  = dq_pend_q;
      dqs_merge = dqs_pend_q;
      for (int p = 0; p < NPHASES; p++) begin
         for (int j = 0; j < WDEPTH; j++) begin
            if (dfi_wrdata_en[p]) begin
               if (j == p + int'(wrlat_q))
                  dq_merge[j] = 1'b1;
               if ((j >= p + int'(wrlat_q) - 1) && (j <= p + int'(wrlat_q) + 1))
                  dqs_merge[j] = 1'b1;
            end
         end
      end
      oe_dq_d    = dq_merge[NPHASES-1:0];
      oe_dqs_d   = dqs_merge[NPHASES-1:0];
      dq_pend_d  = dq_merge >> NPHASES;
      dqs_pend_d = dqs_merge >> NPHASES;
   end

   // Read valids: insert the enable rdlat-1 entries deep, pop entry 0 into the output register.
   always_comb begin
      for (int j = 0; j < RDLAT_MAX; j++) begin
         rd_merge[j] = rd_pipe_q[j];
         if (j == int'(rdlat_q) - 1)
            rd_merge[j] = rd_pipe_q[j] | dfi_rddata_en;
      end
      valid_d = rd_merge[0];
      for (int j = 0; j < RDLAT_MAX - 1; j++)
         rd_pipe_d[j] = rd_merge[j + 1];
      rd_pipe_d[RDLAT_MAX-1] = '0;
   end

   // Occupancy, idle, config acceptance and protocol check.
   always_comb begin
      busy = (|dq_pend_q) | (|dqs_pend_q) | (|oe_dq_q) | (|oe_dqs_q) | (|valid_q);
      for (int j = 0; j < RDLAT_MAX; j++)
         busy = busy | (|rd_pipe_q[j]);
      idle   = ~busy & ~(|dfi_wrdata_en) & ~(|dfi_rddata_en);
      cfg_ok = idle
             && (cfg_rdlat != '0) && (int'(cfg_rdlat) <= RDLAT_MAX)
             && (cfg_wrlat != '0) && (int'(cfg_wrlat) <= WRLAT_MAX);
      rdlat_d = rdlat_q;
      wrlat_d = wrlat_q;
      if (cfg_load && cfg_ok) begin
         rdlat_d = cfg_rdlat;
         wrlat_d = cfg_wrlat;
      end
      cfg_err_d   = cfg_load & ~cfg_ok;
      proto_err_d = (|dfi_wrdata_en) & (|dfi_rddata_en);
   end

   // State and registered outputs; reset aborts every in-flight window and valid.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dq_pend_q   <= '0;
         dqs_pend_q  <= '0;
         rd_pipe_q   <= '{default: '0};
         oe_dq_q     <= '0;
         oe_dqs_q    <= '0;
         valid_q     <= '0;
         rdlat_q     <= LAT_W'(RDLAT_RST);
         wrlat_q     <= LAT_W'(WRLAT_RST);
         cfg_err_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         dq_pend_q   <= dq_pend_d;
         dqs_pend_q  <= dqs_pend_d;
         rd_pipe_q   <= rd_pipe_d;
         oe_dq_q     <= oe_dq_d;
         oe_dqs_q    <= oe_dqs_d;
         valid_q     <= valid_d;
         rdlat_q     <= rdlat_d;
         wrlat_q     <= wrlat_d;
         cfg_err_q   <= cfg_err_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign oe_dq            = oe_dq_q;
   assign oe_dqs           = oe_dqs_q;
   assign dfi_rddata_valid = valid_q;
   assign cfg_err          = cfg_err_q;
   assign proto_err        = proto_err_q;

endmodule

// File: tb/tb_dfi_phase_sequencer.sv
// Directed bench for dfi_phase_sequencer (NPHASES=2, default latencies).
// Expected outputs are queued against a cycle number when stimulus is driven and compared when that cycle arrives.
// Inputs are driven 2 time units after the rising edge; outputs are sampled before new inputs are applied.
module tb_dfi_phase_sequencer;

   localparam int SDQ = 0, SDQS = 1, SVLD = 2, SCE = 3, SPE = 4, SIDLE = 5;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       cfg_load = 1'b0;
   logic [3:0] cfg_rdlat = '0;
   logic [3:0] cfg_wrlat = '0;
   logic [1:0] wr = '0;
   logic [1:0] rd = '0;
   logic [1:0] valid, oe_dq, oe_dqs;
   logic       idle, cfg_err, proto_err;

   int cyc = 0;
   int errors = 0;
   int checks = 0;

   typedef struct {
      int         cyc;
      int         sig;
      logic [1:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];

   dfi_phase_sequencer dut (
      .sys_clk          (sys_clk),
      .sys_rst          (sys_rst),
      .cfg_load         (cfg_load),
      .cfg_rdlat        (cfg_rdlat),
      .cfg_wrlat        (cfg_wrlat),
      .dfi_wrdata_en    (wr),
      .dfi_rddata_en    (rd),
      .dfi_rddata_valid (valid),
      .oe_dq            (oe_dq),
      .oe_dqs           (oe_dqs),
      .idle             (idle),
      .cfg_err          (cfg_err),
      .proto_err        (proto_err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [1:0] sample(int sig);
      case (sig)
         SDQ:     return oe_dq;
         SDQS:    return oe_dqs;
         SVLD:    return valid;
         SCE:     return {1'b0, cfg_err};
         SPE:     return {1'b0, proto_err};
         default: return {1'b0, idle};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Queue an expectation in cycle order.
   task automatic expect_at(input int c, input int sig, input logic [1:0] v, input string tag);
      exp_t e;
      int   i;
      e.cyc = c;
      e.sig = sig;
      e.exp = v;
      e.tag = tag;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, e);
   endtask

   // Advance one cycle, release the one-shot inputs, then compare everything due this cycle.
   task automatic step();
      exp_t e;
      @(posedge sys_clk);
      #1;
      cyc++;
      wr = '0;
      rd = '0;
      cfg_load = 1'b0;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk(e.tag, sample(e.sig), e.exp);
      end
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   initial begin
      int b, c;

      // Reset state
      steps(2);
      chk("rst_oe_dq", oe_dq, 2'b00);
      chk("rst_oe_dqs", oe_dqs, 2'b00);
      chk("rst_valid", valid, 2'b00);
      chk("rst_cfg_err", {1'b0, cfg_err}, 2'b00);
      chk("rst_proto_err", {1'b0, proto_err}, 2'b00);
      chk("rst_idle", {1'b0, idle}, 2'b01);
      sys_rst = 1'b0;
      steps(2);

      // Single write on phase 1, wrlat=3
      step(); b = cyc; wr = 2'b10; #1;
      chk("wr1_idle_busy", {1'b0, idle}, 2'b00);
      expect_at(b+1, SDQS, 2'b00, "wr1_dqs_b1");
      expect_at(b+2, SDQS, 2'b10, "wr1_dqs_pre");
      expect_at(b+2, SDQ,  2'b00, "wr1_dq_b2");
      expect_at(b+3, SDQ,  2'b01, "wr1_dq_burst");
      expect_at(b+3, SDQS, 2'b11, "wr1_dqs_burst");
      expect_at(b+3, SIDLE, 2'b00, "wr1_idle_last");
      expect_at(b+4, SDQ,  2'b00, "wr1_dq_end");
      expect_at(b+4, SDQS, 2'b00, "wr1_dqs_end");
      expect_at(b+4, SIDLE, 2'b01, "wr1_idle_after");
      steps(6);

      // Back-to-back writes
      step(); b = cyc; wr = 2'b10;
      expect_at(b+2, SDQS, 2'b10, "b2b_dqs_pre");
      expect_at(b+3, SDQ,  2'b01, "b2b_dq_1");
      expect_at(b+3, SDQS, 2'b11, "b2b_dqs_1");
      expect_at(b+4, SDQ,  2'b01, "b2b_dq_2");
      expect_at(b+4, SDQS, 2'b11, "b2b_dqs_2");
      expect_at(b+5, SDQ,  2'b00, "b2b_dq_end");
      expect_at(b+5, SDQS, 2'b00, "b2b_dqs_end");
      step(); wr = 2'b10;
      steps(7);

      // Reads, rdlat=4
      step(); b = cyc; rd = 2'b01;
      expect_at(b+3, SVLD, 2'b00, "rd_early");
      expect_at(b+4, SVLD, 2'b01, "rd_first");
      expect_at(b+5, SVLD, 2'b11, "rd_second");
      expect_at(b+6, SVLD, 2'b00, "rd_end");
      step(); rd = 2'b11;
      steps(7);

      // Read and write in one cycle
      step(); b = cyc; wr = 2'b10; rd = 2'b01;
      expect_at(b+1, SPE,  2'b01, "pe_pulse");
      expect_at(b+2, SPE,  2'b00, "pe_clear");
      expect_at(b+2, SDQS, 2'b10, "pe_dqs_pre");
      expect_at(b+3, SDQ,  2'b01, "pe_dq");
      expect_at(b+4, SVLD, 2'b01, "pe_valid");
      steps(6);

      // Config load during a burst, and alongside an enable
      step(); b = cyc; wr = 2'b10;
      expect_at(b+2, SCE, 2'b01, "cfg_busy_err");
      expect_at(b+3, SCE, 2'b00, "cfg_busy_clear");
      step(); cfg_load = 1'b1; cfg_rdlat = 4'd2; cfg_wrlat = 4'd2;
      steps(6);
      step(); b = cyc; rd = 2'b01; cfg_load = 1'b1; cfg_rdlat = 4'd2; cfg_wrlat = 4'd2; #1;
      chk("cfg_same_idle", {1'b0, idle}, 2'b00);
      expect_at(b+1, SCE,  2'b01, "cfg_same_err");
      expect_at(b+3, SVLD, 2'b00, "cfg_same_rd_early");
      expect_at(b+4, SVLD, 2'b01, "cfg_same_rd_lat4");
      steps(6);

      // Out-of-range values are rejected and latencies stay at 4/3
      step(); b = cyc; cfg_load = 1'b1; cfg_rdlat = 4'd2; cfg_wrlat = 4'd0;
      expect_at(b+1, SCE, 2'b01, "cfg_wrlat0_err");
      expect_at(b+2, SCE, 2'b01, "cfg_rdlat0_err");
      expect_at(b+3, SCE, 2'b01, "cfg_wrlat8_err");
      step(); cfg_load = 1'b1; cfg_rdlat = 4'd0; cfg_wrlat = 4'd2;
      step(); cfg_load = 1'b1; cfg_rdlat = 4'd2; cfg_wrlat = 4'd8;
      step(); c = cyc; wr = 2'b10; rd = 2'b01;
      expect_at(c+1, SCE,  2'b00, "cfg_bad_clear");
      expect_at(c+3, SDQ,  2'b01, "cfg_bad_wrlat_kept");
      expect_at(c+3, SVLD, 2'b00, "cfg_bad_rd_early");
      expect_at(c+4, SVLD, 2'b01, "cfg_bad_rdlat_kept");
      steps(6);

      // Minimum latencies 1/1
      step(); b = cyc; cfg_load = 1'b1; cfg_rdlat = 4'd1; cfg_wrlat = 4'd1;
      expect_at(b+1, SCE, 2'b00, "cfg_min_ok");
      step(); rd = 2'b01; wr = 2'b01;
      expect_at(b+2, SVLD, 2'b01, "min_valid");
      expect_at(b+2, SDQ,  2'b10, "min_dq");
      expect_at(b+2, SDQS, 2'b11, "min_dqs_1");
      expect_at(b+3, SDQS, 2'b01, "min_dqs_post");
      expect_at(b+3, SDQ,  2'b00, "min_dq_end");
      expect_at(b+3, SVLD, 2'b00, "min_valid_end");
      steps(4);

      // Maximum latencies 15/7
      step(); b = cyc; cfg_load = 1'b1; cfg_rdlat = 4'd15; cfg_wrlat = 4'd7;
      expect_at(b+1, SCE, 2'b00, "cfg_max_ok");
      step(); c = cyc; rd = 2'b01; wr = 2'b10;
      expect_at(c+3,  SDQS, 2'b00, "max_dqs_early");
      expect_at(c+4,  SDQS, 2'b10, "max_dqs_pre");
      expect_at(c+4,  SDQ,  2'b00, "max_dq_early");
      expect_at(c+5,  SDQ,  2'b01, "max_dq");
      expect_at(c+5,  SDQS, 2'b11, "max_dqs_burst");
      expect_at(c+6,  SDQS, 2'b00, "max_dqs_end");
      expect_at(c+14, SVLD, 2'b00, "max_rd_early");
      expect_at(c+15, SVLD, 2'b01, "max_rd");
      expect_at(c+16, SVLD, 2'b00, "max_rd_end");
      steps(17);

      // Reset in the middle of a write burst with a read in flight
      step(); b = cyc; wr = 2'b10;
      expect_at(b+4,  SDQS, 2'b10, "rstm_pre_seen");
      expect_at(b+5,  SDQ,  2'b00, "rstm_dq");
      expect_at(b+5,  SDQS, 2'b00, "rstm_dqs");
      expect_at(b+5,  SVLD, 2'b00, "rstm_valid");
      expect_at(b+5,  SIDLE, 2'b01, "rstm_idle");
      expect_at(b+6,  SDQS, 2'b00, "rstm_no_post");
      expect_at(b+16, SVLD, 2'b00, "rstm_rd_aborted");
      step(); rd = 2'b01;
      steps(3);
      sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
      steps(11);
      // Latencies back to 4/3
      step(); c = cyc; wr = 2'b10; rd = 2'b01;
      expect_at(c+2, SDQS, 2'b10, "rstm_lat_dqs");
      expect_at(c+3, SDQ,  2'b01, "rstm_wrlat3");
      expect_at(c+3, SVLD, 2'b00, "rstm_rd_early");
      expect_at(c+4, SVLD, 2'b01, "rstm_rdlat4");
      steps(6);

      // Anything left in the scoreboard was never reached
      for (int k = 0; k < 40 && sb.size() > 0; k++) step();
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed=%0d pending expected=0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
